// File: rtl/mips_main_control.sv
// -----------------------------------------------------------------------------
// mips_main_control
//
// Multi-cycle MIPS main control FSM. Walks each instruction through
// fetch / decode / execute / memory / writeback. Every datapath enable and
// mux select is decoded from the state register alone (Moore machine).
//
// Optional feature (compile-time macro MAIN_CTRL_ILLEGAL_TRAP_EN):
//   defined   - an unrecognised opcode in DECODE parks the FSM in TRAP and
//               raises the sticky illegal_op flag until rst_n is asserted.
//   undefined - an unrecognised opcode in DECODE returns to FETCH, so the
//               instruction behaves as a 2-cycle NOP. illegal_op is tied to 0.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (state -> FETCH)
//   opcode      instruction[31:26] from the instruction register
//   pc_write    unconditional PC load
//   branch      PC load qualified by ALU zero
//   iord        memory address select (0 = PC, 1 = ALUOut)
//   mem_read    memory read strobe
//   mem_write   memory write strobe
//   ir_write    instruction register load
//   reg_dst     write register select (0 = rt, 1 = rd)
//   mem_to_reg  writeback data select (0 = ALUOut, 1 = MDR)
//   reg_write   register file write enable
//   alu_src_a   ALU A select (0 = PC, 1 = A)
//   alu_src_b   ALU B select (00 = B, 01 = 4, 10 = imm, 11 = imm<<2)
//   alu_op      ALU operation class (00 add, 01 sub, 10 R-type funct)
//   pc_src      PC source (00 ALU result, 01 ALUOut, 10 jump target)
//   instr_done  one-cycle pulse in the final state of each instruction
//   illegal_op  sticky illegal-opcode flag
//   state       current state code (debug)
// -----------------------------------------------------------------------------
module mips_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  output logic       pc_write,
  output logic       branch,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  state_t     state_r;
  state_t     next_state_s;

  logic       pc_write_s;
  logic       branch_s;
  logic       iord_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_dst_s;
  logic       mem_to_reg_s;
  logic       reg_write_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic [1:0] pc_src_s;
  logic       instr_done_s;

  // State register: asynchronous clear to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic. opcode is only consulted in DECODE and MEMADR.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        next_state_s = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW,
          OP_SW:    next_state_s = S_MEMADR;
          OP_RTYPE: next_state_s = S_EXEC;
          OP_BEQ:   next_state_s = S_BRANCH;
          OP_ADDI:  next_state_s = S_ADDIEX;
          OP_J:     next_state_s = S_JUMP;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
          default:  next_state_s = S_TRAP;
`else
          default:  next_state_s = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        // opcode is re-sampled; if it drifted away from lw/sw, abandon.
        if (opcode == OP_LW) begin
          next_state_s = S_MEMRD;
        end else if (opcode == OP_SW) begin
          next_state_s = S_MEMWR;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_MEMRD:  next_state_s = S_MEMWB;
      S_EXEC:   next_state_s = S_ALUWB;
      S_ADDIEX: next_state_s = S_ADDIWB;
      S_MEMWB,
      S_MEMWR,
      S_ALUWB,
      S_ADDIWB,
      S_BRANCH,
      S_JUMP:   next_state_s = S_FETCH;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:   next_state_s = S_TRAP;
`else
      S_TRAP:   next_state_s = S_FETCH;
`endif
      default:  next_state_s = S_FETCH;
    endcase
  end

  // Moore output decode: every output defaults to 0, states raise their own.
  always_comb begin
    pc_write_s   = 1'b0;
    branch_s     = 1'b0;
    iord_s       = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_write_s  = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    pc_src_s     = 2'b00;
    instr_done_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        ir_write_s  = 1'b1;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b00;
        pc_write_s  = 1'b1;
        pc_src_s    = 2'b00;
      end
      S_DECODE: begin
        // Precompute the branch target PC + (imm << 2) while decoding.
        alu_src_b_s = 2'b11;
        alu_op_s    = 2'b00;
      end
      S_MEMADR,
      S_ADDIEX: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        alu_op_s    = 2'b00;
      end
      S_MEMRD: begin
        iord_s     = 1'b1;
        mem_read_s = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg_s = 1'b1;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      S_MEMWR: begin
        iord_s       = 1'b1;
        mem_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b00;
        alu_op_s    = 2'b10;
      end
      S_ALUWB: begin
        reg_dst_s    = 1'b1;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_s  = 1'b1;
        alu_op_s     = 2'b01;
        pc_src_s     = 2'b01;
        branch_s     = 1'b1;
        instr_done_s = 1'b1;
      end
      S_ADDIWB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      S_JUMP: begin
        pc_src_s     = 2'b10;
        pc_write_s   = 1'b1;
        instr_done_s = 1'b1;
      end
      S_TRAP: begin
        // Everything held inactive; only reset leaves this state.
        pc_write_s = 1'b0;
      end
      default: begin
        pc_write_s = 1'b0;
      end
    endcase
  end

  // Strobes and enables are gated by rst_n so nothing fires while in reset,
  // even though the held FETCH state would otherwise assert them.
  assign pc_write   = pc_write_s   & rst_n;
  assign branch     = branch_s     & rst_n;
  assign mem_read   = mem_read_s   & rst_n;
  assign mem_write  = mem_write_s  & rst_n;
  assign ir_write   = ir_write_s   & rst_n;
  assign reg_write  = reg_write_s  & rst_n;
  assign instr_done = instr_done_s & rst_n;

  assign iord       = iord_s;
  assign reg_dst    = reg_dst_s;
  assign mem_to_reg = mem_to_reg_s;
  assign alu_src_a  = alu_src_a_s;
  assign alu_src_b  = alu_src_b_s;
  assign alu_op     = alu_op_s;
  assign pc_src     = pc_src_s;
  assign state      = state_r;

`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
  logic illegal_r;

  // Sticky illegal-opcode flag: set on the edge that enters TRAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_r <= 1'b0;
    end else if (next_state_s == S_TRAP) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  assign illegal_op = illegal_r;
`else
  assign illegal_op = 1'b0;
`endif

endmodule
